// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_pkg;

  localparam int unsigned MEM_WORDS_DEF = 144;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned BYTE_SHIFT    = 2;
  localparam int unsigned WORD_W        = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs the UART byte stream into big-endian 32-bit words.
// IMEM_LOADER_CHECKSUM_EN adds a running XOR of every accepted byte.
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_ready_c
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        csum
`endif
);

  logic [1:0]        byte_idx;
  logic [WORD_W-9:0] shift_q;

  // Only the three most recent bytes need storing; the fourth comes straight from the input.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= 2'd0;
      shift_q  <= '0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 2'd1;
      shift_q  <= {shift_q[WORD_W-17:0], byte_data};
    end
  end

  assign word_c       = {shift_q, byte_data};
  assign word_ready_c = byte_en && (byte_idx == 2'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      csum <= 8'h00;
    end else if (byte_en) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian instruction image from the UART into instruction RAM.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned ADDR_W    = 31,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  state_t            state, state_nxt;
  logic [7:0]        len_hi_q, len_hi_nxt;
  logic [CNT_W-1:0]  len_q, len_nxt;
  logic [CNT_W-1:0]  n_c, wl_inc_c;
  logic              busy_nxt, wr_en_nxt, done_nxt, error_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [WORD_W-1:0] wr_data_nxt;
  logic [CNT_W-1:0]  words_loaded_nxt;
  logic              clear_c, byte_en_c, words_full_c, word_ready_c;
  logic [WORD_W-1:0] word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign n_c          = CNT_W'({len_hi_q, rx_data});
  assign wl_inc_c     = words_loaded + CNT_W'(1);
  assign words_full_c = (words_loaded == len_q);
  assign clear_c      = start && ((state == ST_IDLE) || (state == ST_ERR));
  assign byte_en_c    = rx_valid && (state == ST_DATA) && !words_full_c;

  imem_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear_c),
    .byte_en      (byte_en_c),
    .byte_data    (rx_data),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .csum         (csum)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      len_hi_q     <= 8'h00;
      len_q        <= '0;
      busy         <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_nxt;
      len_hi_q     <= len_hi_nxt;
      len_q        <= len_nxt;
      busy         <= busy_nxt;
      wr_en        <= wr_en_nxt;
      wr_addr      <= wr_addr_nxt;
      wr_data      <= wr_data_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
      words_loaded <= words_loaded_nxt;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt        = state;
    len_hi_nxt       = len_hi_q;
    len_nxt          = len_q;
    busy_nxt         = busy;
    wr_en_nxt        = 1'b0;
    wr_addr_nxt      = wr_addr;
    wr_data_nxt      = wr_data;
    done_nxt         = 1'b0;
    error_nxt        = error;
    words_loaded_nxt = words_loaded;

    unique case (state)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_nxt        = ST_LEN_HI;
          busy_nxt         = 1'b1;
          error_nxt        = 1'b0;
          words_loaded_nxt = '0;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_hi_nxt = rx_data;
          state_nxt  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_nxt = n_c;
          if (n_c > CNT_W'(MEM_WORDS)) begin
            state_nxt = ST_ERR;
            busy_nxt  = 1'b0;
            error_nxt = 1'b1;
          end else if (n_c == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
`endif
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // Completion is seen one cycle after the last write so done trails wr_en.
        if (words_full_c) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else if (word_ready_c) begin
          wr_en_nxt        = 1'b1;
          wr_data_nxt      = word_c;
          wr_addr_nxt      = ADDR_W'(words_loaded) << BYTE_SHIFT;
          words_loaded_nxt = wl_inc_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (wl_inc_c == len_q) state_nxt = ST_CSUM;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          busy_nxt = 1'b0;
          if (rx_data == csum) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_ERR;
            error_nxt = 1'b1;
          end
        end
      end
`endif
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        busy, wr_en, done, error;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_byte_cyc;
  logic [30:0] addr_log[$];
  logic [31:0] data_log[$];
  int          wcyc_log[$];

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
      wcyc_log.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_log();
    addr_log.delete();
    data_log.delete();
    wcyc_log.delete();
    done_cnt = 0;
  endtask

  task automatic send_image1(input int gap);
    logic [7:0] img[10] = '{8'h00, 8'h02, 8'h3C, 8'h10, 8'h40, 8'h00,
                            8'h24, 8'h08, 8'hFF, 8'hFF};
    foreach (img[i]) begin
      send_byte(img[i], gap);
      if (i == 9) last_byte_cyc = cyc - (gap - 1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h40, gap);
`endif
  endtask

  task automatic check_image1(input string tag);
    check({tag, "_nwr"}, 64'(addr_log.size()), 64'd2);
    if (addr_log.size() == 2) begin
      check({tag, "_a0"}, 64'(addr_log[0]), 64'h0);
      check({tag, "_d0"}, 64'(data_log[0]), 64'h3C104000);
      check({tag, "_a1"}, 64'(addr_log[1]), 64'h4);
      check({tag, "_d1"}, 64'(data_log[1]), 64'h2408FFFF);
    end
    check({tag, "_ndone"}, 64'(done_cnt), 64'd1);
    check({tag, "_wl"}, 64'(words_loaded), 64'd2);
    check({tag, "_err"}, 64'(error), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wl", 64'(words_loaded), 64'd0);
    check("rst_addr", 64'(wr_addr), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    reset = 1'b0;
    tick(1);

    // Slow stream, one byte every three cycles
    clear_log();
    do_start();
    check("t1_busy", 64'(busy), 64'd1);
    send_image1(3);
    tick(3);
    check_image1("t1");
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (wcyc_log.size() == 2) check("t1_done_lat", 64'(done_cyc - wcyc_log[1]), 64'd1);
`endif

    // Back-to-back bytes
    clear_log();
    do_start();
    send_image1(1);
    tick(4);
    check_image1("t2");
    if (wcyc_log.size() == 2) check("t2_wr_lat", 64'(wcyc_log[1]), 64'(last_byte_cyc));
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t2_done_lat", 64'(done_cyc), 64'(last_byte_cyc + 1));
`endif

    // Oversize length is rejected, then recovered by a new start
    clear_log();
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h91, 1);
    check("t3_err", 64'(error), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 1);
    tick(2);
    check("t3_nwr", 64'(addr_log.size()), 64'd0);
    check("t3_err_hold", 64'(error), 64'd1);
    do_start();
    check("t3_err_clr", 64'(error), 64'd0);
    check("t3_wl_clr", 64'(words_loaded), 64'd0);
    send_image1(2);
    tick(3);
    check_image1("t3");

    // Zero-length image
    clear_log();
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t4_nodone", 64'(done), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    send_byte(8'h01, 1);
    check("t4_bad_csum", 64'(error), 64'd1);
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
`endif
    check("t4_done", 64'(done), 64'd1);
    check("t4_busy_low", 64'(busy), 64'd0);
    tick(1);
    check("t4_done_pulse", 64'(done), 64'd0);
    check("t4_nwr", 64'(addr_log.size()), 64'd0);
    check("t4_err", 64'(error), 64'd0);

    // Reset after the first of two words
    clear_log();
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h3C, 1);
    send_byte(8'h10, 1);
    send_byte(8'h40, 1);
    send_byte(8'h00, 1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_wr_en", 64'(wr_en), 64'd0);
    check("t5_wl", 64'(words_loaded), 64'd0);
    check("t5_addr", 64'(wr_addr), 64'd0);
    check("t5_data", 64'(wr_data), 64'd0);
    send_byte(8'h24, 1);
    send_byte(8'h08, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hFF, 1);
    tick(2);
    check("t5_nwr", 64'(addr_log.size()), 64'd1);
    clear_log();
    do_start();
    send_image1(1);
    tick(4);
    check_image1("t5");

    // Largest legal image
    clear_log();
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h90, 1);
    for (int i = 0; i < 144; i++) begin
      send_byte(8'(i), 1);
      send_byte(8'hA5, 1);
      send_byte(8'h5A, 1);
      send_byte(8'(i), 1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1);
`endif
    tick(3);
    check("t6_nwr", 64'(addr_log.size()), 64'd144);
    if (addr_log.size() == 144) begin
      check("t6_last_addr", 64'(addr_log[143]), 64'h23C);
      check("t6_last_data", 64'(data_log[143]), 64'h8FA55A8F);
    end
    check("t6_wl", 64'(words_loaded), 64'd144);
    check("t6_ndone", 64'(done_cnt), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Single word with good and bad checksums
    clear_log();
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h08, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    send_byte(8'h0B, 1);
    check("t7_done", 64'(done), 64'd1);
    tick(2);
    check("t7_err", 64'(error), 64'd0);
    clear_log();
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h08, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    send_byte(8'h0C, 1);
    check("t7_bad_err", 64'(error), 64'd1);
    check("t7_bad_busy", 64'(busy), 64'd0);
    tick(2);
    check("t7_nwr", 64'(addr_log.size()), 64'd1);
    if (addr_log.size() == 1) begin
      check("t7_addr", 64'(addr_log[0]), 64'h0);
      check("t7_data", 64'(data_log[0]), 64'h08000003);
    end
    check("t7_ndone", 64'(done_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
